// File: rtl/game_draw_sequencer_pkg.sv
// Shared geometry, colour and state definitions for the game draw sequencer.
package game_draw_sequencer_pkg;

    // Screen and sprite geometry
    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int SPRITE_W   = 16;
    localparam int SPRITE_H   = 14;
    localparam int ROW_Y_BASE = 4;
    localparam int ROW_PITCH  = 14;

    localparam logic [7:0] LANE_X0 = 8'd32;
    localparam logic [7:0] LANE_X1 = 8'd72;
    localparam logic [7:0] LANE_X2 = 8'd112;

    // The taxi always sits on the bottom row
    localparam logic [7:0] PLAYER_ROW_VEC = 8'b1000_0000;

    // Colours
    localparam logic [2:0] COL_BLACK    = 3'b000;
    localparam logic [2:0] COL_START    = 3'b001;
    localparam logic [2:0] COL_END      = 3'b100;
    localparam logic [2:0] COL_WIN      = 3'b010;
    localparam logic [2:0] COL_TAXI     = 3'b011;
    localparam logic [2:0] COL_EXPLODE  = 3'b100;
    localparam logic [2:0] COL_OBSTACLE = 3'b111;
    localparam logic [2:0] COL_BANANA   = 3'b110;

    // Pending-request bit positions
    localparam int PEND_START    = 0;
    localparam int PEND_END      = 1;
    localparam int PEND_WIN      = 2;
    localparam int PEND_PLAYER   = 3;
    localparam int PEND_OBSTACLE = 4;
    localparam int PEND_BANANA   = 5;
    localparam logic [5:0] PEND_OBJECT_MASK = 6'b111000;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FILL, S_ERASE, S_DRAW, S_DONE
    } drawState_t;

    typedef enum logic [1:0] {
        OBJ_PLAYER   = 2'd0,
        OBJ_OBSTACLE = 2'd1,
        OBJ_BANANA   = 2'd2
    } objId_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] w;
        logic [6:0] h;
    } rect_t;

    localparam rect_t FULL_SCREEN_RECT = '{x: 8'd0, y: 7'd0, w: 8'(SCREEN_W), h: 7'(SCREEN_H)};

    // Index of the lowest set bit of a lane vector (0 when empty)
    function automatic logic [1:0] lowestLane(input logic [2:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = 2; i >= 0; i--) if (v[i]) idx = 2'(i);
        return idx;
    endfunction

    // Index of the lowest set bit of a row vector (0 when empty)
    function automatic logic [2:0] lowestRow(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
        return idx;
    endfunction

    function automatic logic [7:0] laneX(input logic [1:0] lane);
        case (lane)
            2'd0:    return LANE_X0;
            2'd1:    return LANE_X1;
            default: return LANE_X2;
        endcase
    endfunction

    function automatic logic [6:0] rowY(input logic [2:0] row);
        return 7'(ROW_Y_BASE + ROW_PITCH * int'(row));
    endfunction

    // Bounding box of a sprite in a given lane and row
    function automatic rect_t spriteBox(input logic [1:0] lane, input logic [2:0] row);
        rect_t r;
        r.x = laneX(lane);
        r.y = rowY(row);
        r.w = 8'(SPRITE_W);
        r.h = 7'(SPRITE_H);
        return r;
    endfunction

endpackage

// File: rtl/game_draw_sequencer_walker.sv
// Rectangle scanner: walks a box row-major, x fastest, one step per accepted pixel.
module draw_rect_walker
    import game_draw_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  rect_t      rect,
    input  logic       advance,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last
);

    logic [7:0] originX;
    logic [7:0] endX;
    logic [6:0] endY;

    // Load a new box on start, otherwise step to the next pixel on each accept
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x       <= '0;
            y       <= '0;
            originX <= '0;
            endX    <= '0;
            endY    <= '0;
        end else if (start) begin
            // NOTE: non-blocking so every register sees the pre-edge values of the others.
            x       <= rect.x;
            y       <= rect.y;
            originX <= rect.x;
            endX    <= rect.x + rect.w - 8'd1;
            endY    <= rect.y + rect.h - 7'd1;
        end else if (advance) begin
            if (x == endX) begin
                x <= originX;
                y <= y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

    assign last = (x == endX) && (y == endY);

endmodule

// File: rtl/game_draw_sequencer.sv
// Sequences full-screen fills and sprite erase/redraw jobs onto a VGA pixel port.
module game_draw_sequencer
    import game_draw_sequencer_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       startScreenReq,
    input  logic       endScreenReq,
    input  logic       winScreenReq,
    input  logic       playerDrawReq,
    input  logic [2:0] playerPos,
    input  logic       obstacleDrawReq,
    input  logic       bananaDrawReq,
    input  logic [2:0] obstaclePos,
    input  logic [2:0] bananaPos,
    input  logic [7:0] Position,
    input  logic       drawExplosion,
    input  logic       plotReady,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       drawDone
);

    drawState_t state, nextState;
    logic [5:0] reqVec, pending, selMask;

    // Job selection, valid in LOAD
    logic       selAny, selIsFill, selShown;
    objId_t     selObj;
    logic [2:0] selColour, selLaneVec;
    logic [7:0] selRowVec;
    logic [1:0] selLane;
    logic [2:0] selRow;

    // Current job
    logic       jobIsFill, jobShown;
    objId_t     jobObj;
    logic [2:0] jobColour;
    logic [1:0] jobLane;
    logic [2:0] jobRow;

    // Last drawn box of each object
    logic [2:0]       prevValid;
    logic [2:0][1:0]  prevLane;
    logic [2:0][2:0]  prevRow;

    logic  walkStart, walkLast, accept, lastAccept;
    rect_t walkRect;

    assign reqVec = {bananaDrawReq, obstacleDrawReq, playerDrawReq,
                     winScreenReq, endScreenReq, startScreenReq};

    // Pick the highest-priority pending job and the inputs it samples
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        selIsFill  = 1'b0;
        selObj     = OBJ_PLAYER;
        selColour  = COL_BLACK;
        selLaneVec = '0;
        selRowVec  = '0;
        selMask    = '0;
        if (pending[PEND_WIN]) begin
            selIsFill = 1'b1;
            selColour = COL_WIN;
            selMask   = PEND_OBJECT_MASK;
            selMask[PEND_WIN] = 1'b1;
        end else if (pending[PEND_END]) begin
            selIsFill = 1'b1;
            selColour = COL_END;
            selMask   = PEND_OBJECT_MASK;
            selMask[PEND_END] = 1'b1;
        end else if (pending[PEND_START]) begin
            selIsFill = 1'b1;
            selColour = COL_START;
            selMask   = PEND_OBJECT_MASK;
            selMask[PEND_START] = 1'b1;
        end else if (pending[PEND_PLAYER]) begin
            selObj     = OBJ_PLAYER;
            selColour  = drawExplosion ? COL_EXPLODE : COL_TAXI;
            selLaneVec = playerPos;
            selRowVec  = PLAYER_ROW_VEC;
            selMask[PEND_PLAYER] = 1'b1;
        end else if (pending[PEND_OBSTACLE]) begin
            selObj     = OBJ_OBSTACLE;
            selColour  = COL_OBSTACLE;
            selLaneVec = obstaclePos;
            selRowVec  = Position;
            selMask[PEND_OBSTACLE] = 1'b1;
        end else if (pending[PEND_BANANA]) begin
            selObj     = OBJ_BANANA;
            selColour  = COL_BANANA;
            selLaneVec = bananaPos;
            selRowVec  = Position;
            selMask[PEND_BANANA] = 1'b1;
        end
    end

    assign selAny   = |pending;
    assign selShown = (|selLaneVec) && (|selRowVec);
    assign selLane  = lowestLane(selLaneVec);
    assign selRow   = lowestRow(selRowVec);

    assign plot       = (state == S_FILL) || (state == S_ERASE) || (state == S_DRAW);
    assign busy       = (state != S_IDLE);
    assign drawDone   = (state == S_DONE);
    assign colour     = ((state == S_FILL) || (state == S_DRAW)) ? jobColour : COL_BLACK;
    assign accept     = plot && plotReady;
    assign lastAccept = accept && walkLast;

    // Next-state and walker start control
    always_comb begin
        nextState = state;
        walkStart = 1'b0;
        walkRect  = FULL_SCREEN_RECT;
        unique case (state)
            S_IDLE: if (|(pending | reqVec)) nextState = S_LOAD;
            S_LOAD: begin
                if (!selAny) begin
                    nextState = S_IDLE;
                end else if (selIsFill) begin
                    nextState = S_FILL;
                    walkStart = 1'b1;
                end else if (prevValid[selObj]) begin
                    nextState = S_ERASE;
                    walkStart = 1'b1;
                    walkRect  = spriteBox(prevLane[selObj], prevRow[selObj]);
                end else if (selShown) begin
                    nextState = S_DRAW;
                    walkStart = 1'b1;
                    walkRect  = spriteBox(selLane, selRow);
                end else begin
                    nextState = S_DONE;
                end
            end
            S_FILL: if (lastAccept) nextState = S_DONE;
            S_ERASE: begin
                if (lastAccept) begin
                    if (jobShown) begin
                        nextState = S_DRAW;
                        walkStart = 1'b1;
                        walkRect  = spriteBox(jobLane, jobRow);
                    end else begin
                        nextState = S_DONE;
                    end
                end
            end
            S_DRAW: if (lastAccept) nextState = S_DONE;
            S_DONE: nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nextState;
    end

    // Sticky request bits: served bits clear in LOAD, new pulses always land
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) pending <= '0;
        else         pending <= (pending & ~((state == S_LOAD) ? selMask : 6'b0)) | reqVec;
    end

    // Capture the job description in LOAD so later input changes do not disturb it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            jobIsFill <= 1'b0;
            jobObj    <= OBJ_PLAYER;
            jobColour <= COL_BLACK;
            jobShown  <= 1'b0;
            jobLane   <= '0;
            jobRow    <= '0;
        end else if (state == S_LOAD) begin
            jobIsFill <= selIsFill;
            jobObj    <= selObj;
            jobColour <= selColour;
            jobShown  <= selShown;
            jobLane   <= selLane;
            jobRow    <= selRow;
        end
    end

    // Previous-box store: invalidated by fills, updated when an object job completes
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: this store is tiny, so it is reset; prevValid alone would gate the stale boxes.
            prevValid <= '0;
            prevLane  <= '0;
            prevRow   <= '0;
        end else if (state == S_LOAD && selAny && selIsFill) begin
            prevValid <= '0;
        end else if (state == S_DONE && !jobIsFill) begin
            prevValid[jobObj] <= jobShown;
            prevLane[jobObj]  <= jobLane;
            prevRow[jobObj]   <= jobRow;
        end
    end

    draw_rect_walker u_walker (
        .clock   (clock),
        .resetn  (resetn),
        .start   (walkStart),
        .rect    (walkRect),
        .advance (accept),
        .x       (x),
        .y       (y),
        .last    (walkLast)
    );

endmodule

// File: tb/tb_game_draw_sequencer.sv
// Scoreboard bench for game_draw_sequencer: expected pixels are queued with each request.
module tb_game_draw_sequencer;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    logic       clock;
    logic       resetn;
    logic       startScreenReq, endScreenReq, winScreenReq;
    logic       playerDrawReq, obstacleDrawReq, bananaDrawReq;
    logic [2:0] playerPos, obstaclePos, bananaPos;
    logic [7:0] Position;
    logic       drawExplosion, plotReady;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, drawDone;

    pixel_t expQ[$];
    int     testsRun   = 0;
    int     failures   = 0;
    int     jobAccepts = 0;

    logic   prevStall = 1'b0;
    pixel_t stallPix;
    pixel_t monGot, monWant;

    game_draw_sequencer dut (
        .clock           (clock),
        .resetn          (resetn),
        .startScreenReq  (startScreenReq),
        .endScreenReq    (endScreenReq),
        .winScreenReq    (winScreenReq),
        .playerDrawReq   (playerDrawReq),
        .playerPos       (playerPos),
        .obstacleDrawReq (obstacleDrawReq),
        .bananaDrawReq   (bananaDrawReq),
        .obstaclePos     (obstaclePos),
        .bananaPos       (bananaPos),
        .Position        (Position),
        .drawExplosion   (drawExplosion),
        .plotReady       (plotReady),
        .x               (x),
        .y               (y),
        .colour          (colour),
        .plot            (plot),
        .busy            (busy),
        .drawDone        (drawDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: pops the scoreboard on each accepted pixel and checks stall stability
    always @(negedge clock) begin
        if (resetn !== 1'b1) begin
            prevStall = 1'b0;
        end else begin
            monGot = '{x: x, y: y, colour: colour};
            if (prevStall) begin
                testsRun++;
                if (plot !== 1'b1 || monGot !== stallPix) begin
                    failures++;
                    $display("FAIL stall_hold: got plot=%b x=%0d y=%0d c=%b, required plot=1 x=%0d y=%0d c=%b",
                             plot, x, y, colour, stallPix.x, stallPix.y, stallPix.colour);
                end
            end
            if (plot === 1'b1 && plotReady === 1'b1) begin
                jobAccepts++;
                testsRun++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%b, required no pixel", x, y, colour);
                end else begin
                    monWant = expQ.pop_front();
                    if (monGot !== monWant) begin
                        failures++;
                        $display("FAIL pixel: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b",
                                 x, y, colour, monWant.x, monWant.y, monWant.colour);
                    end
                end
            end
            prevStall = (plot === 1'b1) && (plotReady === 1'b0);
            stallPix  = monGot;
        end
    end

    // Hard time limit in case the design never goes idle
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pushBox(input int x0, input int y0, input logic [2:0] c);
        for (int yy = 0; yy < 14; yy++)
            for (int xx = 0; xx < 16; xx++)
                expQ.push_back('{x: 8'(x0 + xx), y: 7'(y0 + yy), colour: c});
    endtask

    task automatic pushFill(input logic [2:0] c);
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                expQ.push_back('{x: 8'(xx), y: 7'(yy), colour: c});
    endtask

    // Run cycles until the given number of drawDone pulses, optionally throttling plotReady
    task automatic waitJobs(input int jobs, input bit randomReady, input int budget, input string name);
        int         seen;
        int         cyc;
        logic [3:0] pat;
        seen = 0;
        cyc  = 0;
        pat  = 4'b1001;
        while (seen < jobs && cyc < budget) begin
            @(posedge clock); #1;
            if (randomReady) plotReady = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
            @(negedge clock);
            if (drawDone === 1'b1) seen++;
            cyc++;
        end
        plotReady = 1'b1;
        testsRun++;
        if (seen != jobs) begin
            failures++;
            $display("FAIL %s_timeout: got %0d jobs done, required %0d", name, seen, jobs);
        end
    endtask

    task automatic test_reset();
        int bad;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        testsRun++;
        if ({plot, busy, drawDone} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got plot/busy/done=%b, required 000", {plot, busy, drawDone});
        end
        testsRun++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'b000) begin
            failures++;
            $display("FAIL reset_pixel: got x=%0d y=%0d c=%b, required 0 0 000", x, y, colour);
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (plot !== 1'b0 || busy !== 1'b0) bad++;
        end
        testsRun++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_quiet: got %0d active cycles, required 0", bad);
        end
    endtask

    task automatic test_fill();
        int n;
        pushFill(3'b001);
        @(posedge clock); #1;
        startScreenReq = 1'b1;
        @(negedge clock);
        testsRun++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_cycle_n: got plot=%b busy=%b, required 0 0", plot, busy);
        end
        @(posedge clock); #1;
        startScreenReq = 1'b0;
        @(negedge clock);
        testsRun++;
        if (plot !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fill_load: got plot=%b busy=%b, required 0 1", plot, busy);
        end
        @(negedge clock);
        testsRun++;
        if (plot !== 1'b1) begin
            failures++;
            $display("FAIL fill_latency: got plot=%b at N+2, required 1", plot);
        end
        n = 0;
        while (drawDone !== 1'b1 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        testsRun++;
        if (n != 19200) begin
            failures++;
            $display("FAIL fill_done_cycle: got %0d cycles after first plot, required 19200", n);
        end
        testsRun++;
        if (busy !== 1'b1 || plot !== 1'b0) begin
            failures++;
            $display("FAIL fill_done_state: got busy=%b plot=%b, required 1 0", busy, plot);
        end
        @(negedge clock);
        testsRun++;
        if (drawDone !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL fill_idle: got done=%b busy=%b, required 0 0", drawDone, busy);
        end
        testsRun++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL fill_count: got %0d pixels missing, required 0", expQ.size());
        end
    endtask

    task automatic test_player_move();
        playerPos = 3'b010;
        pushBox(72, 102, 3'b011);
        @(posedge clock); #1; playerDrawReq = 1'b1;
        @(posedge clock); #1; playerDrawReq = 1'b0;
        waitJobs(1, 1'b0, 1000, "player_first");
        playerPos = 3'b100;
        pushBox(72, 102, 3'b000);
        pushBox(112, 102, 3'b011);
        @(posedge clock); #1; playerDrawReq = 1'b1;
        @(posedge clock); #1; playerDrawReq = 1'b0;
        waitJobs(1, 1'b0, 1000, "player_move");
        testsRun++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL player_move_count: got %0d pixels missing, required 0", expQ.size());
        end
    endtask

    task automatic test_stall();
        obstaclePos = 3'b001;
        Position    = 8'b0000_0100;
        pushBox(32, 32, 3'b111);
        jobAccepts = 0;
        @(posedge clock); #1; obstacleDrawReq = 1'b1;
        @(posedge clock); #1; obstacleDrawReq = 1'b0;
        waitJobs(1, 1'b1, 3000, "stall");
        testsRun++;
        if (jobAccepts != 224) begin
            failures++;
            $display("FAIL stall_accepts: got %0d, required 224", jobAccepts);
        end
        testsRun++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL stall_count: got %0d pixels missing, required 0", expQ.size());
        end
    endtask

    task automatic test_hidden();
        // Move obstacle to lane 1 row 0: erase old box then draw new
        obstaclePos = 3'b010;
        Position    = 8'b0000_0001;
        pushBox(32, 32, 3'b000);
        pushBox(72, 4, 3'b111);
        @(posedge clock); #1; obstacleDrawReq = 1'b1;
        @(posedge clock); #1; obstacleDrawReq = 1'b0;
        waitJobs(1, 1'b0, 1000, "hidden_move");
        // Not shown: erase only
        obstaclePos = 3'b000;
        pushBox(72, 4, 3'b000);
        jobAccepts = 0;
        @(posedge clock); #1; obstacleDrawReq = 1'b1;
        @(posedge clock); #1; obstacleDrawReq = 1'b0;
        waitJobs(1, 1'b0, 1000, "hidden_erase");
        testsRun++;
        if (jobAccepts != 224) begin
            failures++;
            $display("FAIL hidden_erase_only: got %0d accepts, required 224", jobAccepts);
        end
        // Multi-bit vectors pick the lowest bit; previous box is invalid so no erase
        obstaclePos = 3'b101;
        Position    = 8'b1010_0100;
        pushBox(32, 32, 3'b111);
        jobAccepts = 0;
        @(posedge clock); #1; obstacleDrawReq = 1'b1;
        @(posedge clock); #1; obstacleDrawReq = 1'b0;
        waitJobs(1, 1'b0, 1000, "hidden_reshow");
        testsRun++;
        if (jobAccepts != 224) begin
            failures++;
            $display("FAIL hidden_reshow: got %0d accepts, required 224", jobAccepts);
        end
        testsRun++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL hidden_count: got %0d pixels missing, required 0", expQ.size());
        end
    endtask

    task automatic test_priority();
        int bad;
        playerPos = 3'b001;
        bananaPos = 3'b010;
        Position  = 8'b0000_0001;
        pushBox(112, 102, 3'b000);
        pushBox(32, 102, 3'b011);
        pushFill(3'b100);
        @(posedge clock); #1; playerDrawReq = 1'b1;
        @(posedge clock); #1; playerDrawReq = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        testsRun++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL priority_busy: got busy=%b, required 1", busy);
        end
        bananaDrawReq = 1'b1;
        endScreenReq  = 1'b1;
        @(posedge clock); #1;
        bananaDrawReq = 1'b0;
        endScreenReq  = 1'b0;
        waitJobs(2, 1'b0, 25000, "priority");
        bad = 0;
        repeat (30) begin
            @(negedge clock);
            if (busy !== 1'b0 || plot !== 1'b0) bad++;
        end
        testsRun++;
        if (bad != 0) begin
            failures++;
            $display("FAIL priority_banana_dropped: got %0d busy cycles, required 0", bad);
        end
        testsRun++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL priority_count: got %0d pixels missing, required 0", expQ.size());
        end
    endtask

    task automatic test_explosion();
        drawExplosion = 1'b1;
        playerPos     = 3'b100;
        pushBox(112, 102, 3'b100);
        @(posedge clock); #1; playerDrawReq = 1'b1;
        @(posedge clock); #1; playerDrawReq = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        playerPos = 3'b001;
        waitJobs(1, 1'b0, 1000, "explosion");
        drawExplosion = 1'b0;
        testsRun++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL explosion_count: got %0d pixels missing, required 0", expQ.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int bad;
        pushFill(3'b010);
        jobAccepts = 0;
        @(posedge clock); #1; winScreenReq = 1'b1;
        @(posedge clock); #1; winScreenReq = 1'b0;
        cyc = 0;
        while (jobAccepts < 100 && cyc < 500) begin
            @(negedge clock); #1;
            cyc++;
        end
        testsRun++;
        if (jobAccepts != 100) begin
            failures++;
            $display("FAIL reset_mid_reach: got %0d accepts, required 100", jobAccepts);
        end
        resetn = 1'b0;
        #1;
        testsRun++;
        if (plot !== 1'b0 || busy !== 1'b0 || drawDone !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: got plot=%b busy=%b done=%b, required 0 0 0", plot, busy, drawDone);
        end
        @(negedge clock);
        testsRun++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_pixel: got x=%0d y=%0d c=%b, required 0 0 000", x, y, colour);
        end
        @(posedge clock); #1;
        resetn = 1'b1;
        expQ.delete();
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (plot !== 1'b0 || busy !== 1'b0) bad++;
        end
        testsRun++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, required 0", bad);
        end
    endtask

    initial begin
        resetn          = 1'b0;
        startScreenReq  = 1'b0;
        endScreenReq    = 1'b0;
        winScreenReq    = 1'b0;
        playerDrawReq   = 1'b0;
        obstacleDrawReq = 1'b0;
        bananaDrawReq   = 1'b0;
        playerPos       = 3'b000;
        obstaclePos     = 3'b000;
        bananaPos       = 3'b000;
        Position        = 8'h00;
        drawExplosion   = 1'b0;
        plotReady       = 1'b1;

        test_reset();
        test_fill();
        test_player_move();
        test_stall();
        test_hidden();
        test_priority();
        test_explosion();
        test_reset_mid();

        testsRun++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL final_queue: got %0d pixels outstanding, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/game_draw_sequencer.md
GAME_DRAW_SEQUENCER -- requirements
Module: game_draw_sequencer

Interface
REQ-001 clock  in  1  single system clock; all state updates on its rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 startScreenReq / endScreenReq / winScreenReq  in  1 each  one-cycle pulses, full-screen fill request.
REQ-004 playerDrawReq  in  1  pulse; redraw taxi using playerPos.
REQ-005 playerPos  in  3  lane one-hot (bit0 left, bit1 middle, bit2 right).
REQ-006 obstacleDrawReq / bananaDrawReq  in  1 each  pulse; redraw that object.
REQ-007 obstaclePos / bananaPos  in  3  lane one-hot of object.
REQ-008 Position  in  8  row one-hot of obstacle and banana; bit0 top, bit7 bottom.
REQ-009 drawExplosion  in  1  level; taxi drawn in explosion colour while high.
REQ-010 plotReady  in  1  VGA adapter accepts the current pixel when plot && plotReady.
REQ-011 x  out  8, y  out  7, colour  out  3  pixel coordinate and colour.
REQ-012 plot  out  1  pixel valid.
REQ-013 busy  out  1  high whenever not IDLE.
REQ-014 drawDone  out  1  one-cycle pulse after last accepted pixel of a job.

Function
REQ-015 Screen 160x120; sprite box 16 wide x 14 tall; lane x origin 32/72/112; row k y origin 4+14k; taxi fixed at row 7.
REQ-016 Lane index = lowest set bit of lane vector; row index = lowest set bit of Position; an all-zero vector means "not shown": erase only, no draw.
REQ-017 Request pulses set sticky pending bits, sampled every cycle including while busy; no request is ever lost.
REQ-018 Job priority when leaving IDLE: fill (win > end > start) > player > obstacle > banana.
REQ-019 Starting a fill job clears all pending object bits and invalidates all stored previous boxes.
REQ-020 Object job = ERASE (previous box, colour 000, skipped if invalid) then DRAW (new box, skipped if not shown); new box stored as previous at end of DRAW.
REQ-021 Lane/row inputs sampled in the cycle the job starts; later changes affect only the next job.
REQ-022 Colours: start 001, end 100, win 010, taxi 011 (100 while drawExplosion), obstacle 111, banana 110.
REQ-023 States: IDLE, LOAD, FILL, ERASE, DRAW, DONE; IDLE->LOAD when any pending; LOAD->FILL or ERASE; ERASE->DRAW; FILL/DRAW->DONE after last accepted pixel; DONE->IDLE.
REQ-024 Pixel order row-major, x fastest; x/y/colour advance only on accepted pixel; while plot && !plotReady all outputs hold stable.
REQ-025 Latency: request pulse in IDLE at cycle N -> first plot at N+2.
REQ-026 Pixel counts: fill 19200, box 224; accepted-pixel totals are exact, no duplicates, no skips.
REQ-027 drawDone asserted in DONE only; busy low only in IDLE.

Reset
REQ-028 resetn low: state IDLE, pending bits 0, previous boxes invalid, plot 0, busy 0, drawDone 0, x 0, y 0, colour 000.
REQ-029 Reset mid-job aborts immediately; no plot after resetn deasserts until a new request.

Structure
REQ-030 Shared package holds screen size, sprite size, lane x origins, row y base/pitch and colour constants.
REQ-031 One sub-module draw_rect_walker: given origin, width, height, start pulse and plotReady, steps x/y and flags last pixel.

Verification
REQ-032 startScreenReq pulse, plotReady=1 -> 19200 plots colour 001 covering (0,0)-(159,119), drawDone at pixel count+1 cycle.
REQ-033 playerPos=010 then playerDrawReq, then playerPos=100 and playerDrawReq -> second job erases x72..87,y102..115 with 000 then draws x112..127 colour 011.
REQ-034 plotReady toggled 1,0,0,1 randomly during obstacle draw (Position=00000100, lane 001) -> outputs frozen during stalls, exactly 224 accepted pixels at x32..47,y32..45.
REQ-035 bananaDrawReq and endScreenReq same cycle while busy -> after current job, end fill runs, banana job never executes.
REQ-036 drawExplosion high during player draw -> all taxi pixels colour 100.
REQ-037 resetn low at pixel 100 of a fill -> plot 0 next cycle, busy 0, no further plots with no requests.
